// File: rtl/proc_pkg.sv
// Shared definitions for the matrix processor and its batch scheduler:
// opcode encodings, instruction field positions and scheduler state encoding.
package proc_pkg;

    localparam int INST_W = 64;
    localparam int RES_W  = 32;

    localparam int OPC_MSB = 60;
    localparam int OPC_LSB = 56;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00010;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_TRAN = 5'b01000;
    localparam logic [OPC_W-1:0] OP_DET  = 5'b10000;

    // Operands are packed 4-bit elements; element 0 of each sits at the field LSB
    localparam int ELEM_W  = 4;
    localparam int OPND_W  = 28;
    localparam int OPA_LSB = 0;
    localparam int OPB_LSB = 28;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_SKIP, S_FIN
    } sched_state_e;

    function automatic logic [OPC_W-1:0] opc_of(input logic [INST_W-1:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/proc_batch_sched_if.sv
// Scheduler bus: batch control, instruction memory read port, processor
// handshake and result memory write port.
interface proc_batch_sched_if #(parameter int ADDR_W = 4);
    logic              start;
    logic [ADDR_W:0]   cfg_len;
    logic              busy;
    logic              batch_done;
    logic [ADDR_W:0]   err_cnt;
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [63:0]       imem_rdata;
    logic              inst_valid;
    logic [63:0]       p_rdata;
    logic [31:0]       p_wdata;
    logic              done;
    logic              rmem_we;
    logic [ADDR_W-1:0] rmem_addr;
    logic [31:0]       rmem_wdata;
    logic              rmem_err;

    modport master (
        input  start, cfg_len, imem_rdata, p_wdata, done,
        output busy, batch_done, err_cnt, imem_rd, imem_addr, inst_valid,
               p_rdata, rmem_we, rmem_addr, rmem_wdata, rmem_err
    );

    modport slave (
        output start, cfg_len, imem_rdata, p_wdata, done,
        input  busy, batch_done, err_cnt, imem_rd, imem_addr, inst_valid,
               p_rdata, rmem_we, rmem_addr, rmem_wdata, rmem_err
    );
endinterface

// File: rtl/proc_opc_chk.sv
// Combinational opcode validity check: the field must be exactly one of the
// one-hot processor opcodes.
module proc_opc_chk
    import proc_pkg::*;
(
    input  logic [OPC_W-1:0] opc,
    output logic             valid
);
    assign valid = opc inside {OP_ADD, OP_SUB, OP_MUL, OP_TRAN, OP_DET};
endmodule

// File: rtl/proc_batch_sched.sv
// Batch scheduler: fetches instructions, issues valid ones to the processor,
// writes results (or error entries) to the result memory. Optional macro SCHED_WDOG_EN adds a WAIT watchdog.
module proc_batch_sched
    import proc_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int WDOG_CYC = 15
) (
    input  logic               clk,
    input  logic               rst,
    proc_batch_sched_if.master bus
);
    localparam int LW = ADDR_W + 1;

    sched_state_e      state, state_nx;
    logic [ADDR_W-1:0] idx;
    logic [LW-1:0]     len;
    logic [LW-1:0]     err_cnt_q;
    logic [INST_W-1:0] inst_q;
    logic [RES_W-1:0]  res_q;
    logic [OPC_W-1:0]  ld_opc;
    logic              opc_ok;
    logic              last;
    logic              wdog_exp;

    assign ld_opc = opc_of(bus.imem_rdata);

    proc_opc_chk u_opc_chk (
        .opc   (ld_opc),
        .valid (opc_ok)
    );

    // len is at least 1 whenever this is consulted, so idx never wraps
    assign last = (LW'(idx) + LW'(1)) == len;

`ifdef SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wdog <= '0;
        else if (state == S_WAIT) wdog <= wdog + WD_W'(1);
        else                      wdog <= '0;
    end

    // Fires on the WDOG_CYC-th WAIT cycle; a done in that same cycle still wins
    assign wdog_exp = (wdog == WD_W'(WDOG_CYC - 1));
`else
    assign wdog_exp = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nx = (bus.cfg_len == '0) ? S_FIN : S_FETCH;
            S_FETCH: state_nx = S_LOAD;
            S_LOAD:  state_nx = opc_ok ? S_ISSUE : S_SKIP;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (bus.done)    state_nx = S_WRITE;
                else if (wdog_exp) state_nx = S_SKIP;
            end
            S_WRITE, S_SKIP: state_nx = last ? S_FIN : S_FETCH;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            len       <= '0;
            err_cnt_q <= '0;
            inst_q    <= '0;
            res_q     <= '0;
        end else begin
            if (state == S_IDLE && bus.start) begin
                len       <= bus.cfg_len;
                err_cnt_q <= '0;
                idx       <= '0;
            end
            if (state == S_LOAD)              inst_q    <= bus.imem_rdata;
            if (state == S_WAIT && bus.done)  res_q     <= bus.p_wdata;
            if (state == S_SKIP)              err_cnt_q <= err_cnt_q + LW'(1);
            if ((state == S_WRITE || state == S_SKIP) && !last) idx <= idx + ADDR_W'(1);
        end
    end

    always_comb begin
        bus.busy       = (state != S_IDLE);
        bus.batch_done = (state == S_FIN);
        bus.err_cnt    = err_cnt_q;
        bus.imem_rd    = (state == S_FETCH);
        bus.imem_addr  = idx;
        bus.inst_valid = (state == S_ISSUE);
        bus.p_rdata    = inst_q;
        bus.rmem_we    = (state == S_WRITE) || (state == S_SKIP);
        bus.rmem_addr  = idx;
        bus.rmem_wdata = (state == S_WRITE) ? res_q : '0;
        bus.rmem_err   = (state == S_SKIP);
    end

endmodule

// File: doc/proc_batch_sched.md
Name: proc_batch_sched

Overview:
- Batch scheduler sitting in front of the matrix `processor` datapath.
- On `start`, it walks `cfg_len` 64-bit instruction words out of a synchronous instruction memory.
- It issues each valid instruction to the processor through the `inst_valid`/`p_rdata` handshake, waits for `done`, and writes the 32-bit `p_wdata` result into a result memory at the same index.
- Words with malformed opcodes are skipped and flagged, never issued; this protects the processor, which would otherwise drop to IDLE without ever raising `done`.

Parameters:
- ADDR_W, 4, instruction/result memory address width; batch depth up to 2^ADDR_W.
- WDOG_CYC, 15, watchdog limit in WAIT cycles; used only when SCHED_WDOG_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin batch; sampled only in IDLE
- cfg_len  in  ADDR_W+1  instruction count, 0..2^ADDR_W; sampled with start
- busy  out  1  high in every state except IDLE
- batch_done  out  1  one-cycle pulse at end of batch
- err_cnt  out  ADDR_W+1  count of flagged entries in the current/last batch
- imem_rd  out  1  instruction memory read strobe
- imem_addr  out  ADDR_W  read address
- imem_rdata  in  64  read data, valid exactly 1 cycle after imem_rd
- inst_valid  out  1  one-cycle issue pulse to the processor
- p_rdata  out  64  instruction word to the processor, held stable from ISSUE until WRITE
- p_wdata  in  32  processor result
- done  in  1  processor completion, a one-cycle pulse
- rmem_we  out  1  result write enable
- rmem_addr  out  ADDR_W  result address, equal to the instruction index
- rmem_wdata  out  32  result data
- rmem_err  out  1  error flag written alongside rmem_wdata

Behaviour:
- Reset values: all outputs 0; state IDLE; idx 0; len 0.
- Outputs are decoded from state and registers (Moore); no combinational path from any input to any output.
- IDLE: if start, latch cfg_len and clear err_cnt.
  - cfg_len == 0 -> FIN.
  - otherwise idx = 0 -> FETCH.
- FETCH: imem_rd = 1, imem_addr = idx -> LOAD.
- LOAD: latch imem_rdata into the p_rdata register. Opcode = bits [60:56].
  - exactly one of 00001/00010/00100/01000/10000 -> ISSUE.
  - any other value -> SKIP.
- ISSUE: inst_valid = 1 for exactly one cycle -> WAIT.
- WAIT: on done, latch p_wdata into the result register -> WRITE.
  - done arrives on the 4th WAIT cycle; the bench checks this.
  - done in any state other than WAIT is ignored.
- WRITE: rmem_we = 1, rmem_addr = idx, rmem_wdata = result, rmem_err = 0.
- SKIP: rmem_we = 1, rmem_wdata = 0, rmem_err = 1, err_cnt += 1.
- After WRITE or SKIP:
  - idx == len-1 -> FIN.
  - otherwise idx += 1 -> FETCH.
- FIN: batch_done = 1 -> IDLE.
- Cycle counts: a valid instruction costs 8 cycles (FETCH, LOAD, ISSUE, WAIT x4, WRITE); a skipped one costs 3.
  - A batch of N valid instructions raises batch_done on cycle 8N+1 after the edge that samples start.
- start is ignored while busy. The next issue is never earlier than 2 cycles after done.
- len == 2^ADDR_W: idx reaches all-ones, then FIN; idx never wraps.
- rst mid-batch: immediate return to IDLE, no further memory writes. The processor shares rst.
- err_cnt holds its value after FIN until the next accepted start.

Optional Feature:
- Macro SCHED_WDOG_EN.
- Defined: a counter runs in WAIT.
  - After WDOG_CYC cycles without done, go to SKIP-equivalent handling: write 0 with rmem_err = 1, err_cnt += 1, then continue.
  - A done arriving after the timeout is ignored.
- Undefined: WAIT waits indefinitely; no counter logic.

Decomposition:
- Shared package `proc_pkg`:
  - opcode localparams OP_ADD/OP_SUB/OP_MUL/OP_TRAN/OP_DET;
  - opcode field bit positions [60:56];
  - operand field positions;
  - scheduler state encoding.
- One sub-module, `proc_opc_chk`: combinational one-hot opcode validity check on a 5-bit field. It is reusable by any future instruction source.

Test Plan:
- cfg_len = 1, imem[0] = 64'h0100_0000_4000_0003 (ADD, A0 = 3, B0 = 4) -> rmem[0] = 32'h0000_0007, rmem_err = 0, batch_done on cycle 9 after start, err_cnt = 0.
- cfg_len = 3, imem[1] opcode = 00011 (invalid), others valid ADD -> inst_valid pulses exactly twice, rmem[1] = 0 with rmem_err = 1, err_cnt = 1, batch_done on cycle 20.
- cfg_len = 0 -> batch_done on the cycle after start; no imem_rd, inst_valid or rmem_we.
- cfg_len = 16 (ADDR_W = 4), all valid -> addresses 0..15 written once each, no wrap, batch_done on cycle 129.
- start pulsed while busy, plus a spurious done during FETCH -> no effect on sequence or results.
- rst asserted during WAIT -> all outputs 0 next cycle, no rmem_we. With SCHED_WDOG_EN and a stubbed processor that never raises done, rmem_err = 1 after 15 WAIT cycles.
